multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_if.sv | 29 ++
 rtl/multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Memory handshake bundle between the multicycle control unit and the memory.
//   mem_req   : control unit -> memory, access request for the current cycle
//   mem_read  : control unit -> memory, request is a read (fetch or load)
//   mem_write : control unit -> memory, request is a write (store)
//   mem_ready : memory -> control unit, completion of the current request
// The control unit uses the master modport, the memory side uses slave.
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multicycle CPU control FSM: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   opcode          : instruction opcode, latched in DECODE
//   branch_taken    : branch condition from the ALU, used in EXECUTE only
//   mem (master)    : mem_req/mem_read/mem_write out, mem_ready in
//   pc_write, ir_write, mem_to_regs, alu_src, reg_write, branch : strobes
//   alu_operation   : ALU function select, nonzero only in EXECUTE
//   state           : current state encoding
//   trap_cause      : 0 none, 1 illegal opcode, 2 fetch timeout, 3 mem timeout
//   retired         : retired-instruction counter (wraps)
// Strobes are combinational from state, latched opcode, mem_ready and
// branch_taken so that memory completion is acknowledged in the same cycle.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    multicycle_control_unit_if.master mem,
    output logic                    pc_write,
    output logic                    ir_write,
    output logic                    mem_to_regs,
    output logic                    alu_src,
    output logic                    reg_write,
    output logic                    branch,
    output logic [ALU_OP_W-1:0]     alu_operation,
    output logic [2:0]              state,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        retired
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    // Wide enough to reach MEM_TIMEOUT; with the timeout disabled it may wrap.
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [1:0]           trap_q, trap_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;

    logic pc_write_s, ir_write_s, mem_req_s, mem_write_s, mem_read_s;
    logic mem_to_regs_s, alu_src_s, reg_write_s, branch_s, retire_s;
    logic [ALU_OP_W-1:0] alu_op_s;
    logic timeout_s;

    assign timeout_s = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    // Next-state, strobe decode and bookkeeping updates.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        trap_d        = trap_q;
        wait_d        = {WAIT_W{1'b0}};
        retire_s      = 1'b0;
        pc_write_s    = 1'b0;
        ir_write_s    = 1'b0;
        mem_req_s     = 1'b0;
        mem_write_s   = 1'b0;
        mem_read_s    = 1'b0;
        mem_to_regs_s = 1'b0;
        alu_src_s     = 1'b0;
        reg_write_s   = 1'b0;
        branch_s      = 1'b0;
        alu_op_s      = {ALU_OP_W{1'b0}};
        case (state_q)
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                mem_read_s = 1'b1;
                // Completion wins over a timeout in the same cycle.
                if (mem.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                    trap_d  = 2'd2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1'b1);
                end
            end
            ST_DECODE: begin
                opcode_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 2'd1;
                end
            end
            ST_EXECUTE: begin
                case (opcode_q)
                    OP_R: begin
                        alu_op_s = ALU_OP_W'(3'd2);
                        state_d  = ST_WB;
                    end
                    OP_I: begin
                        alu_src_s = 1'b1;
                        alu_op_s  = ALU_OP_W'(3'd2);
                        state_d   = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_s = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op_s   = ALU_OP_W'(3'd7);
                        branch_s   = 1'b1;
                        pc_write_s = branch_taken;
                        retire_s   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s   = 1'b1;
                mem_read_s  = (opcode_q == OP_LOAD);
                mem_write_s = (opcode_q == OP_STORE);
                if (mem.mem_ready) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                    trap_d  = 2'd3;
                end else begin
                    wait_d = wait_q + WAIT_W'(1'b1);
                end
            end
            ST_WB: begin
                reg_write_s   = 1'b1;
                mem_to_regs_s = (opcode_q == OP_LOAD);
                retire_s      = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 7'h00;
            trap_q    <= 2'd0;
            retired_q <= {CNT_W{1'b0}};
            wait_q    <= {WAIT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    // Output drive; reset forces every strobe and the ALU select low.
    always_comb begin
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem.mem_req   = 1'b0;
            mem.mem_write = 1'b0;
            mem.mem_read  = 1'b0;
            mem_to_regs   = 1'b0;
            alu_src       = 1'b0;
            reg_write     = 1'b0;
            branch        = 1'b0;
            alu_operation = {ALU_OP_W{1'b0}};
        end else begin
            pc_write      = pc_write_s;
            ir_write      = ir_write_s;
            mem.mem_req   = mem_req_s;
            mem.mem_write = mem_write_s;
            mem.mem_read  = mem_read_s;
            mem_to_regs   = mem_to_regs_s;
            alu_src       = alu_src_s;
            reg_write     = reg_write_s;
            branch        = branch_s;
            alu_operation = alu_op_s;
        end
    end

    assign state      = state_q;
    assign trap_cause = trap_q;
    assign retired    = retired_q;

endmodule
